// File: rtl/lcd_panel_rx.sv
// HD44780-style LCD bus receiver: samples e/rs/data, decodes commands and data
// writes into a 128x8 DDRAM, and models the controller's busy window.
module lcd_panel_rx #(
  parameter int MIN_E_CYC    = 4,
  parameter int BUSY_CYC     = 100,
  parameter int CLR_BUSY_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       incr,
  output logic       shift,
  output logic       func_8bit,
  output logic       lines2,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_rs,
  output logic       busy,
  output logic       err_short_e,
  output logic       err_busy,
  input  logic       err_clr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_E_HIGH = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam int WW = $clog2(MIN_E_CYC + 1);

  logic       e_meta_q, e_s_q, rs_meta_q, rs_s_q;
  logic [7:0] d_meta_q, d_s_q;
  logic [1:0] state_q, state_d;
  logic [WW-1:0] width_q, width_d;
  logic       cap_rs_q, cap_rs_d;
  logic [7:0] cap_d_q, cap_d_d;
  logic [6:0] cursor_q, cursor_d;
  logic       disp_on_q, disp_on_d, incr_q, incr_d, shift_q, shift_d;
  logic       func_8bit_q, func_8bit_d, lines2_q, lines2_d;
  logic       cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic [19:0] busy_cnt_q, busy_cnt_d;
  logic       fill_active_q, fill_active_d;
  logic [6:0] fill_addr_q, fill_addr_d;
  logic       err_short_q, err_short_d, err_busy_q, err_busy_d;
  logic       short_set, busy_set;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] ddram_q [128];
  logic [7:0] rd_char_q;

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    cap_rs_d      = cap_rs_q;
    cap_d_d       = cap_d_q;
    cursor_d      = cursor_q;
    disp_on_d     = disp_on_q;
    incr_d        = incr_q;
    shift_d       = shift_q;
    func_8bit_d   = func_8bit_q;
    lines2_d      = lines2_q;
    cmd_valid_d   = 1'b0;
    cmd_byte_d    = cmd_byte_q;
    cmd_rs_d      = cmd_rs_q;
    busy_cnt_d    = (busy_cnt_q != 20'd0) ? busy_cnt_q - 20'd1 : 20'd0;
    fill_active_d = fill_active_q;
    fill_addr_d   = fill_addr_q;
    short_set     = 1'b0;
    busy_set      = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = fill_addr_q;
    mem_wdata     = 8'h20;

    if (fill_active_q) begin
      mem_we      = 1'b1;
      fill_addr_d = fill_addr_q + 7'd1;
      if (fill_addr_q == 7'h7F) fill_active_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        width_d = '0;
        if (e_s_q) state_d = ST_E_HIGH;
      end
      ST_E_HIGH: begin
        if (width_q < WW'(MIN_E_CYC)) width_d = width_q + 1'b1;
        cap_rs_d = rs_s_q;
        cap_d_d  = d_s_q;
        if (!e_s_q) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        width_d = '0;
        state_d = e_s_q ? ST_E_HIGH : ST_IDLE;
        if (width_q < WW'(MIN_E_CYC)) begin
          short_set = 1'b1;
        end else if (busy_cnt_q != 20'd0) begin
          busy_set = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_byte_d  = cap_d_q;
          cmd_rs_d    = cap_rs_q;
          busy_cnt_d  = 20'(BUSY_CYC);
          if (cap_rs_q) begin
            mem_we    = 1'b1;
            mem_waddr = cursor_q;
            mem_wdata = cap_d_q;
            cursor_d  = incr_q ? cursor_q + 7'd1 : cursor_q - 7'd1;
          end else if (cap_d_q[7]) begin
            cursor_d = cap_d_q[6:0];
          end else if (cap_d_q[6]) begin
            cursor_d = cursor_q;
          end else if (cap_d_q[5]) begin
            func_8bit_d = cap_d_q[4];
            lines2_d    = cap_d_q[3];
          end else if (cap_d_q[4]) begin
            cursor_d = cursor_q;
          end else if (cap_d_q[3]) begin
            disp_on_d = cap_d_q[2];
          end else if (cap_d_q[2]) begin
            incr_d  = cap_d_q[1];
            shift_d = cap_d_q[0];
          end else if (cap_d_q[1]) begin
            cursor_d   = 7'd0;
            busy_cnt_d = 20'(CLR_BUSY_CYC);
          end else if (cap_d_q[0]) begin
            cursor_d      = 7'd0;
            incr_d        = 1'b1;
            fill_active_d = 1'b1;
            fill_addr_d   = 7'd0;
            busy_cnt_d    = 20'(CLR_BUSY_CYC);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a new error event outranks a simultaneous clear
    err_short_d = (err_short_q & ~err_clr) | short_set;
    err_busy_d  = (err_busy_q & ~err_clr) | busy_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_meta_q <= 1'b0; e_s_q <= 1'b0; rs_meta_q <= 1'b0; rs_s_q <= 1'b0;
      d_meta_q <= 8'd0; d_s_q <= 8'd0;
      state_q <= ST_IDLE; width_q <= '0; cap_rs_q <= 1'b0; cap_d_q <= 8'd0;
      cursor_q <= 7'd0; disp_on_q <= 1'b0; incr_q <= 1'b1; shift_q <= 1'b0;
      func_8bit_q <= 1'b1; lines2_q <= 1'b0;
      cmd_valid_q <= 1'b0; cmd_byte_q <= 8'd0; cmd_rs_q <= 1'b0;
      // power-up clear: fill and busy window start on release
      busy_cnt_q <= 20'(CLR_BUSY_CYC);
      fill_active_q <= 1'b1; fill_addr_q <= 7'd0;
      err_short_q <= 1'b0; err_busy_q <= 1'b0;
    end else begin
      e_meta_q <= lcd_e; e_s_q <= e_meta_q;
      rs_meta_q <= lcd_rs; rs_s_q <= rs_meta_q;
      d_meta_q <= lcd_data; d_s_q <= d_meta_q;
      state_q <= state_d; width_q <= width_d; cap_rs_q <= cap_rs_d; cap_d_q <= cap_d_d;
      cursor_q <= cursor_d; disp_on_q <= disp_on_d; incr_q <= incr_d; shift_q <= shift_d;
      func_8bit_q <= func_8bit_d; lines2_q <= lines2_d;
      cmd_valid_q <= cmd_valid_d; cmd_byte_q <= cmd_byte_d; cmd_rs_q <= cmd_rs_d;
      busy_cnt_q <= busy_cnt_d;
      fill_active_q <= fill_active_d; fill_addr_q <= fill_addr_d;
      err_short_q <= err_short_d; err_busy_q <= err_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) ddram_q[mem_waddr] <= mem_wdata;
    rd_char_q <= ddram_q[rd_addr];
  end

  assign rd_char     = rd_char_q;
  assign cursor_addr = cursor_q;
  assign disp_on     = disp_on_q;
  assign incr        = incr_q;
  assign shift       = shift_q;
  assign func_8bit   = func_8bit_q;
  assign lines2      = lines2_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign cmd_rs      = cmd_rs_q;
  assign busy        = (busy_cnt_q != 20'd0);
  assign err_short_e = err_short_q;
  assign err_busy    = err_busy_q;

endmodule

// File: doc/lcd_panel_rx.md
LCD_PANEL_RX -- requirements
Module: lcd_panel_rx

Interface
REQ-001 SHALL provide parameter MIN_E_CYC, default 4: minimum synchronized e-high cycles for a valid transfer.
REQ-002 SHALL provide parameter BUSY_CYC, default 100: busy cycles after an accepted ordinary command or character write.
REQ-003 SHALL provide parameter CLR_BUSY_CYC, default 200: busy cycles after clear or home; legal range 128..2^20-1.
REQ-004 SHALL provide port: clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL provide port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL provide ports: lcd_rs  in  1  register select (0 = command, 1 = data); lcd_e  in  1  enable strobe; lcd_data  in  8  bus byte.
REQ-007 SHALL provide ports: rd_addr  in  7  DDRAM read address; rd_char  out  8  DDRAM read data.
REQ-008 SHALL provide ports: cursor_addr  out  7; disp_on  out  1; incr  out  1; shift  out  1; func_8bit  out  1; lines2  out  1.
REQ-009 SHALL provide ports: cmd_valid  out  1  one-cycle accept pulse; cmd_byte  out  8  accepted byte; cmd_rs  out  1  accepted rs.
REQ-010 SHALL provide ports: busy  out  1; err_short_e  out  1  sticky; err_busy  out  1  sticky; err_clr  in  1  clears both error flags.

Function
REQ-011 SHALL pass lcd_e, lcd_rs and lcd_data through a 2-flop synchronizer; the synchronized values are e_s, rs_s and d_s.
REQ-012 SHALL use FSM IDLE -> E_HIGH on e_s rise; in IDLE, the width counter clears.
REQ-013 In E_HIGH, SHALL increment the width counter, saturating at MIN_E_CYC, and SHALL capture rs_s/d_s every cycle.
REQ-014 SHALL transition E_HIGH -> DECODE when e_s falls.
REQ-015 DECODE SHALL last one cycle, then go to E_HIGH if e_s is high, else to IDLE.
REQ-016 In DECODE with width < MIN_E_CYC: SHALL set err_short_e, discard the byte, and assert no cmd_valid.
REQ-017 In DECODE with busy=1 and width OK: SHALL set err_busy and discard the byte.
REQ-018 Otherwise in DECODE: SHALL accept the byte, pulse cmd_valid with cmd_byte/cmd_rs registered that same cycle, execute the byte, and load the busy counter.
REQ-019 busy SHALL equal (busy counter != 0); the counter SHALL decrement by 1 per cycle.
REQ-020 Command decode (rs=0) SHALL use highest-set-bit priority, as follows.
REQ-021 Command 1aaaaaaa: cursor_addr = a.
REQ-022 Command 01xxxxxx (CGRAM) and 0001xxxx (shift): accepted with no state change.
REQ-023 Command 001DNxxx: func_8bit = D, lines2 = N.
REQ-024 Command 00001Dxx: disp_on = D.
REQ-025 Command 000001IS: incr = I, shift = S.
REQ-026 Command 0000001x (home): cursor_addr = 0; busy load = CLR_BUSY_CYC.
REQ-027 Command 00000001 (clear): cursor_addr = 0, incr = 1; start the fill; busy load = CLR_BUSY_CYC.
REQ-028 Command 0x00: accepted no-op.
REQ-029 Command busy load SHALL be BUSY_CYC unless stated otherwise in REQ-021 to REQ-028.
REQ-030 Data (rs=1): SHALL write DDRAM[cursor_addr] = byte, then set cursor_addr +1 if incr, else -1, modulo 128 (0x7F+1 -> 0x00, 0x00-1 -> 0x7F).
REQ-031 shift SHALL be stored only, with no display effect.
REQ-032 DDRAM SHALL be 128x8 with one write port.
REQ-033 The fill SHALL write 0x20 to addresses 0..127, one per cycle, starting the cycle after the trigger, and SHALL complete within 128 cycles.
REQ-034 rd_char SHALL register DDRAM[rd_addr] with 1-cycle latency; mid-fill reads SHALL return current (partially cleared) contents.
REQ-035 When err_clr coincides with a new error event, the error set SHALL win.

Reset
REQ-036 While rst is high: FSM = IDLE; synchronizers = 0; cursor_addr = 0; disp_on = 0; incr = 1; shift = 0; func_8bit = 1; lines2 = 0; cmd_valid = 0; cmd_byte = 0; cmd_rs = 0; err flags = 0.
REQ-037 On rst release: a fill SHALL start and the busy counter SHALL be loaded with CLR_BUSY_CYC, so busy = 1 the first cycle after release.
REQ-038 rst asserted mid-fill or mid-transfer SHALL abort the operation, and the fill SHALL restart from address 0 on release.

Verification
REQ-039 Scenario: release rst, hold lcd_e=0 -> busy=1 for 200 cycles; then rd_addr=0x45 gives rd_char=0x20.
REQ-040 Scenario: 10-cycle e pulses of 0x85 (rs=0), then 0x41 (rs=1), spaced 150 cycles -> cmd_valid pulses 0x85 then 0x41; DDRAM[5]=0x41; cursor_addr=6.
REQ-041 Scenario: bytes 0x04, 0x80, then data 0x42 -> DDRAM[0]=0x42; cursor_addr=0x7F; incr=0.
REQ-042 Scenario: 2-cycle e pulse of 0x0C -> err_short_e=1; disp_on=0; no cmd_valid. Then pulse err_clr -> err_short_e=0.
REQ-043 Scenario: two data writes 50 cycles apart -> second sets err_busy; DDRAM and cursor_addr reflect only the first.
REQ-044 Scenario: after writes, send 0x01 -> every address reads 0x20; cursor_addr=0; busy for 200 cycles. Assert rst at fill cycle 60 -> fill restarts and all addresses read 0x20 afterward.
